// File: rtl/if_inject_sched.sv
// Intermittent-fault experiment sequencer: drives LFSR stimulus into a faulty and a golden
// netlist copy, pulses one fault site in periodic bursts and gathers mismatch statistics.
module if_inject_sched #(
    parameter int NIN   = 11,
    parameter int NOUT  = 4,
    parameter int NSITE = 32,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       cfg_site,
    input  logic [1:0]       cfg_type,
    input  logic [7:0]       cfg_burst,
    input  logic [7:0]       cfg_gap,
    input  logic [7:0]       cfg_nburst,
    input  logic [NIN-1:0]   cfg_seed,
    output logic [NIN-1:0]   vec_out,
    output logic [NSITE-1:0] fault_en,
    output logic [1:0]       fault_type,
    input  logic [NOUT-1:0]  cut_out,
    input  logic [NOUT-1:0]  gold_out,
    output logic             busy,
    output logic             done,
    output logic             smp_valid,
    output logic             smp_label,
    output logic [NOUT-1:0]  smp_diff,
    output logic [CW-1:0]    mism_cnt,
    output logic [CW-1:0]    first_mism
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GAP   = 3'd2,
        S_BURST = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] SITE_LIM = 32'(NSITE);

    state_t           r_state;
    state_t           w_next;
    logic             w_phase_end;
    logic             w_start;
    logic             w_active;
    logic             w_enter_active;
    logic             w_site_ok;
    logic [NSITE-1:0] w_onehot;
    logic [NIN-1:0]   w_lfsr_next;
    logic [NOUT-1:0]  w_sample_diff;

    logic [4:0]       r_site;
    logic [1:0]       r_type;
    logic [7:0]       r_blen;
    logic [7:0]       r_gap;
    logic [7:0]       r_nburst;
    logic [NIN-1:0]   r_lfsr;
    logic [7:0]       r_phase;
    logic [7:0]       r_bcnt;
    logic [CW-1:0]    r_cyc;
    logic [CW-1:0]    r_tag;
    logic [NIN-1:0]   r_vec;
    logic [NSITE-1:0] r_fault_en;
    logic             r_busy;
    logic             r_done;
    logic             r_smp_valid;
    logic             r_smp_label;
    logic [NOUT-1:0]  r_smp_diff;
    logic [CW-1:0]    r_mism;
    logic [CW-1:0]    r_first;

    assign w_start        = (r_state == S_IDLE) && start;
    assign w_active       = (r_state == S_GAP) || (r_state == S_BURST);
    assign w_enter_active = (w_next == S_GAP) || (w_next == S_BURST);
    assign w_site_ok      = (r_type != 2'b11) && ({27'd0, r_site} < SITE_LIM);
    assign w_onehot       = {{(NSITE-1){1'b0}}, 1'b1} << r_site;
    assign w_lfsr_next    = {r_lfsr[NIN-2:0], r_lfsr[NIN-1] ^ r_lfsr[NIN-3]};
    assign w_sample_diff  = cut_out ^ gold_out;

    // Next-state decode; a phase ends on its last counted cycle.
    always_comb begin
        w_next      = r_state;
        w_phase_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD;
                else       w_next = S_IDLE;
            end
            S_LOAD: begin
                if (r_nburst == 8'd0)  w_next = S_DRAIN;
                else if (r_gap != 8'd0) w_next = S_GAP;
                else                    w_next = S_BURST;
            end
            S_GAP: begin
                w_phase_end = (r_phase == (r_gap - 8'd1));
                if (w_phase_end) w_next = S_BURST;
                else             w_next = S_GAP;
            end
            S_BURST: begin
                w_phase_end = (r_phase == (r_blen - 8'd1));
                if (!w_phase_end)                        w_next = S_BURST;
                else if ((r_bcnt + 8'd1) == r_nburst)    w_next = S_DRAIN;
                else if (r_gap != 8'd0)                  w_next = S_GAP;
                else                                     w_next = S_BURST;
            end
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register, latched run configuration and schedule counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_site   <= 5'd0;
            r_type   <= 2'b00;
            r_blen   <= 8'd1;
            r_gap    <= 8'd0;
            r_nburst <= 8'd0;
            r_lfsr   <= {NIN{1'b1}};
            r_phase  <= 8'd0;
            r_bcnt   <= 8'd0;
            r_cyc    <= {CW{1'b0}};
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_site   <= cfg_site;
                r_type   <= cfg_type;
                r_blen   <= (cfg_burst == 8'd0) ? 8'd1 : cfg_burst;
                r_gap    <= cfg_gap;
                r_nburst <= cfg_nburst;
                r_lfsr   <= (cfg_seed == {NIN{1'b0}}) ? {NIN{1'b1}} : cfg_seed;
                r_bcnt   <= 8'd0;
                r_cyc    <= {CW{1'b0}};
            end else begin
                // The LFSR runs one step ahead of vec_out so the seed is shown first.
                if (w_enter_active) r_lfsr <= w_lfsr_next;
                if ((r_state == S_BURST) && w_phase_end) r_bcnt <= r_bcnt + 8'd1;
                if (w_active) r_cyc <= r_cyc + {{(CW-1){1'b0}}, 1'b1};
            end
            if (w_active && !w_phase_end) r_phase <= r_phase + 8'd1;
            else                          r_phase <= 8'd0;
        end
    end

    // Stimulus, fault enable and run-status outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec      <= {NIN{1'b0}};
            r_fault_en <= {NSITE{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_enter_active) r_vec <= r_lfsr;
            r_fault_en <= ((w_next == S_BURST) && w_site_ok) ? w_onehot : {NSITE{1'b0}};
            r_busy     <= (w_next == S_LOAD) || w_enter_active || (w_next == S_DRAIN);
            r_done     <= (w_next == S_DONE);
        end
    end

    // Sample pipeline and mismatch statistics; stats lag the visible sample by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_valid <= 1'b0;
            r_smp_label <= 1'b0;
            r_smp_diff  <= {NOUT{1'b0}};
            r_tag       <= {CW{1'b0}};
            r_mism      <= {CW{1'b0}};
            r_first     <= {CW{1'b1}};
        end else if (w_start) begin
            r_smp_valid <= 1'b0;
            r_smp_label <= 1'b0;
            r_smp_diff  <= {NOUT{1'b0}};
            r_tag       <= {CW{1'b0}};
            r_mism      <= {CW{1'b0}};
            r_first     <= {CW{1'b1}};
        end else begin
            if (w_active) begin
                r_smp_valid <= 1'b1;
                r_smp_label <= (r_fault_en != {NSITE{1'b0}});
                r_smp_diff  <= w_sample_diff;
                r_tag       <= r_cyc;
            end else begin
                r_smp_valid <= 1'b0;
            end
            if (r_smp_valid && (r_smp_diff != {NOUT{1'b0}})) begin
                if (r_mism != {CW{1'b1}}) r_mism <= r_mism + {{(CW-1){1'b0}}, 1'b1};
                if (r_first == {CW{1'b1}}) r_first <= r_tag;
            end
        end
    end

    assign vec_out    = r_vec;
    assign fault_en   = r_fault_en;
    assign fault_type = r_type;
    assign busy       = r_busy;
    assign done       = r_done;
    assign smp_valid  = r_smp_valid;
    assign smp_label  = r_smp_label;
    assign smp_diff   = r_smp_diff;
    assign mism_cnt   = r_mism;
    assign first_mism = r_first;

endmodule

// File: tb/tb_if_inject_sched.sv
// Self-checking bench for if_inject_sched: scheduled runs are compared cycle by cycle with a
// phase-list model, plus fixed scenario tables and reset / start-hold sequences.
module tb_if_inject_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  cfg_site = 5'd0;
    logic [1:0]  cfg_type = 2'd0;
    logic [7:0]  cfg_burst = 8'd0;
    logic [7:0]  cfg_gap = 8'd0;
    logic [7:0]  cfg_nburst = 8'd0;
    logic [10:0] cfg_seed = 11'd0;
    logic [10:0] vec_out;
    logic [31:0] fault_en;
    logic [1:0]  fault_type;
    logic [3:0]  cut_out;
    logic [3:0]  gold_out;
    logic        busy, done, smp_valid, smp_label;
    logic [3:0]  smp_diff;
    logic [15:0] mism_cnt, first_mism;

    logic [3:0]  inj_mask = 4'h0;
    logic        inj_dep = 1'b0;

    int n_err = 0;
    int n_chk = 0;

    // Stand-in netlists: the faulty copy flips masked outputs while any site is enabled.
    assign gold_out = vec_out[3:0] ^ vec_out[10:7];
    assign cut_out  = gold_out ^ ((fault_en != 32'd0) ?
                      (inj_mask & (inj_dep ? (vec_out[3:0] | vec_out[7:4]) : 4'hF)) : 4'h0);

    if_inject_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_site(cfg_site), .cfg_type(cfg_type), .cfg_burst(cfg_burst), .cfg_gap(cfg_gap),
        .cfg_nburst(cfg_nburst), .cfg_seed(cfg_seed),
        .vec_out(vec_out), .fault_en(fault_en), .fault_type(fault_type),
        .cut_out(cut_out), .gold_out(gold_out),
        .busy(busy), .done(done), .smp_valid(smp_valid), .smp_label(smp_label),
        .smp_diff(smp_diff), .mism_cnt(mism_cnt), .first_mism(first_mism)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [4:0]  site;
        logic [1:0]  typ;
        logic [7:0]  burst;
        logic [7:0]  gap;
        logic [7:0]  nb;
        logic [10:0] seed;
        logic [3:0]  mask;
        logic [15:0] e_mism;
        logic [15:0] e_first;
        logic [31:0] e_femask;
        int          e_busy;
        logic [10:0] e_v0;
        logic [10:0] e_v1;
    } case_t;

    case_t tbl[5];

    // Model of one run: per GAP/BURST cycle the presented vector, enable and sampled diff.
    logic [10:0] m_vec[$];
    logic [31:0] m_fe[$];
    logic [3:0]  m_diff[$];
    logic [10:0] last_vec = 11'd0;

    logic [31:0] obs_femask;
    int          obs_busy;
    int          obs_s;
    logic [10:0] obs_v0, obs_v1;
    logic [15:0] obs_mism, obs_first;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic build_model(input logic [4:0] site, input logic [1:0] typ,
                               input logic [7:0] burst, input logic [7:0] gap,
                               input logic [7:0] nb, input logic [10:0] seed,
                               input logic [3:0] mask, input logic dep);
        int          blen;
        logic [10:0] v;
        logic [31:0] fe;
        logic [3:0]  d;
        m_vec.delete();
        m_fe.delete();
        m_diff.delete();
        blen = (burst == 8'd0) ? 1 : int'(burst);
        v = (seed == 11'd0) ? 11'h7FF : seed;
        for (int b = 0; b < int'(nb); b++) begin
            for (int p = 0; p < int'(gap) + blen; p++) begin
                fe = ((p >= int'(gap)) && (typ != 2'b11)) ? (32'd1 << site) : 32'd0;
                d  = (fe != 32'd0) ? (mask & (dep ? (v[3:0] | v[7:4]) : 4'hF)) : 4'h0;
                m_vec.push_back(v);
                m_fe.push_back(fe);
                m_diff.push_back(d);
                v = {v[9:0], v[10] ^ v[8]};
            end
        end
    endtask

    function automatic int cnt_upto(input int m);
        int c = 0;
        for (int i = 0; i < m; i++) if (m_diff[i] != 4'h0) c++;
        return c;
    endfunction

    function automatic logic [15:0] first_upto(input int m);
        logic [15:0] f = 16'hFFFF;
        for (int i = m - 1; i >= 0; i--) if (m_diff[i] != 4'h0) f = 16'(i);
        return f;
    endfunction

    task automatic note_sample();
        obs_busy += int'(busy);
        if (obs_s == 0) obs_v0 = vec_out;
        if (obs_s == 1) obs_v1 = vec_out;
        obs_s++;
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_vec"}, vec_out, 32'd0);
        chk({p, "_fault_en"}, fault_en, 32'd0);
        chk({p, "_fault_type"}, fault_type, 32'd0);
        chk({p, "_busy"}, busy, 32'd0);
        chk({p, "_done"}, done, 32'd0);
        chk({p, "_smp_valid"}, smp_valid, 32'd0);
        chk({p, "_smp_label"}, smp_label, 32'd0);
        chk({p, "_smp_diff"}, smp_diff, 32'd0);
        chk({p, "_mism_cnt"}, mism_cnt, 32'd0);
        chk({p, "_first_mism"}, first_mism, 32'hFFFF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_checks("rst");
        @(negedge clk);
        rst_n = 1'b1;
        last_vec = 11'd0;
    endtask

    // One full run from IDLE, checked every cycle; hold keeps start high throughout.
    task automatic run_cfg(input logic [4:0] site, input logic [1:0] typ, input logic [7:0] burst,
                           input logic [7:0] gap, input logic [7:0] nb, input logic [10:0] seed,
                           input logic [3:0] mask, input logic dep, input logic hold);
        int n;
        build_model(site, typ, burst, gap, nb, seed, mask, dep);
        n = m_vec.size();
        obs_femask = 32'd0;
        obs_busy = 0;
        obs_s = 0;
        @(negedge clk);
        cfg_site = site; cfg_type = typ; cfg_burst = burst; cfg_gap = gap;
        cfg_nburst = nb; cfg_seed = seed; inj_mask = mask; inj_dep = dep;
        start = 1'b1;
        @(negedge clk);
        start = hold;
        cfg_site = 5'($urandom); cfg_type = 2'($urandom); cfg_burst = 8'($urandom);
        cfg_gap = 8'($urandom); cfg_nburst = 8'($urandom); cfg_seed = 11'($urandom);
        chk("load_busy", busy, 32'd1);
        chk("load_done", done, 32'd0);
        chk("load_fault_type", fault_type, 32'(typ));
        chk("load_fault_en", fault_en, 32'd0);
        chk("load_smp_valid", smp_valid, 32'd0);
        chk("load_mism_cnt", mism_cnt, 32'd0);
        chk("load_first_mism", first_mism, 32'hFFFF);
        chk("load_vec_hold", vec_out, 32'(last_vec));
        obs_busy += int'(busy);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("run_vec_out", vec_out, 32'(m_vec[k]));
            chk("run_fault_en", fault_en, m_fe[k]);
            chk("run_busy", busy, 32'd1);
            chk("run_done", done, 32'd0);
            chk("run_smp_valid", smp_valid, (k > 0) ? 32'd1 : 32'd0);
            chk("run_smp_label", smp_label, (k > 0 && m_fe[k-1] != 32'd0) ? 32'd1 : 32'd0);
            chk("run_smp_diff", smp_diff, (k > 0) ? 32'(m_diff[k-1]) : 32'd0);
            chk("run_mism_cnt", mism_cnt, 32'(cnt_upto(k - 1)));
            chk("run_first_mism", first_mism, 32'(first_upto(k - 1)));
            if (fault_en != 32'd0 && k < 32) obs_femask |= (32'd1 << k);
            note_sample();
            last_vec = m_vec[k];
        end
        @(negedge clk);
        chk("drain_busy", busy, 32'd1);
        chk("drain_fault_en", fault_en, 32'd0);
        chk("drain_vec_hold", vec_out, 32'(last_vec));
        chk("drain_smp_valid", smp_valid, (n > 0) ? 32'd1 : 32'd0);
        chk("drain_smp_label", smp_label, (n > 0 && m_fe[n-1] != 32'd0) ? 32'd1 : 32'd0);
        chk("drain_smp_diff", smp_diff, (n > 0) ? 32'(m_diff[n-1]) : 32'd0);
        chk("drain_mism_cnt", mism_cnt, 32'(cnt_upto(n - 1)));
        note_sample();
        @(negedge clk);
        chk("done_pulse", done, 32'd1);
        chk("done_busy", busy, 32'd0);
        chk("done_smp_valid", smp_valid, 32'd0);
        chk("done_smp_diff_hold", smp_diff, (n > 0) ? 32'(m_diff[n-1]) : 32'd0);
        chk("done_vec_hold", vec_out, 32'(last_vec));
        chk("done_mism_cnt", mism_cnt, 32'(cnt_upto(n)));
        chk("done_first_mism", first_mism, 32'(first_upto(n)));
        obs_mism = mism_cnt;
        obs_first = first_mism;
        note_sample();
        @(negedge clk);
        chk("idle_done", done, 32'd0);
        chk("idle_busy", busy, 32'd0);
        chk("idle_mism_hold", mism_cnt, 32'(cnt_upto(n)));
        if (hold) begin
            @(negedge clk);
            chk("restart_busy", busy, 32'd1);
            chk("restart_fault_type", fault_type, 32'(cfg_type));
            do_reset();
        end
    endtask

    initial begin
        tbl[0] = '{5'd3, 2'b01, 8'd2, 8'd3, 8'd2, 11'h001, 4'h1, 16'd4, 16'd3, 32'h318, 12, 11'h001, 11'h002};
        tbl[1] = '{5'd3, 2'b11, 8'd2, 8'd3, 8'd2, 11'h001, 4'h1, 16'd0, 16'hFFFF, 32'h0, 12, 11'h001, 11'h002};
        tbl[2] = '{5'd3, 2'b01, 8'd2, 8'd3, 8'd0, 11'h001, 4'h1, 16'd0, 16'hFFFF, 32'h0, 2, 11'h201, 11'h201};
        tbl[3] = '{5'd5, 2'b10, 8'd0, 8'd0, 8'd3, 11'h5A5, 4'h1, 16'd3, 16'd0, 32'h7, 5, 11'h5A5, 11'h34A};
        tbl[4] = '{5'd0, 2'b00, 8'd1, 8'd1, 8'd1, 11'h000, 4'h2, 16'd1, 16'd1, 32'h2, 4, 11'h7FF, 11'h7FE};

        repeat (2) @(negedge clk);
        reset_checks("por");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_cfg(tbl[i].site, tbl[i].typ, tbl[i].burst, tbl[i].gap, tbl[i].nb,
                    tbl[i].seed, tbl[i].mask, 1'b0, 1'b0);
            chk("tbl_mism_cnt", obs_mism, tbl[i].e_mism);
            chk("tbl_first_mism", obs_first, tbl[i].e_first);
            chk("tbl_fault_cycles", obs_femask, tbl[i].e_femask);
            chk("tbl_busy_cycles", obs_busy, tbl[i].e_busy);
            chk("tbl_vec0", obs_v0, 32'(tbl[i].e_v0));
            chk("tbl_vec1", obs_v1, 32'(tbl[i].e_v1));
        end

        // start held high across the whole run, including DONE.
        run_cfg(5'd7, 2'b10, 8'd1, 8'd0, 8'd2, 11'h123, 4'hF, 1'b1, 1'b1);

        // Reset during the second burst of the reference scenario, then rerun it.
        @(negedge clk);
        cfg_site = 5'd3; cfg_type = 2'b01; cfg_burst = 8'd2; cfg_gap = 8'd3;
        cfg_nburst = 8'd2; cfg_seed = 11'h001; inj_mask = 4'h1; inj_dep = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrun_fault_en", fault_en, 32'h8);
        chk("midrun_mism_cnt", mism_cnt, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        last_vec = 11'd0;
        run_cfg(tbl[0].site, tbl[0].typ, tbl[0].burst, tbl[0].gap, tbl[0].nb,
                tbl[0].seed, tbl[0].mask, 1'b0, 1'b0);
        chk("rerun_mism_cnt", obs_mism, tbl[0].e_mism);
        chk("rerun_first_mism", obs_first, tbl[0].e_first);
        chk("rerun_fault_cycles", obs_femask, tbl[0].e_femask);

        for (int r = 0; r < 40; r++) begin
            logic [10:0] sd;
            sd = ($urandom_range(0, 9) == 0) ? 11'd0 : 11'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_cfg(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                    8'($urandom_range(0, 4)), sd, 4'($urandom), 1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
